// File: rtl/mips_boot_ctrl.sv
// Boot sequencer: holds the MIPS core in reset, streams bytes into memory, then releases it.
// Beats write in their accept cycle; in_ready stays high all through LOAD, so the source alone paces the load.
module mips_boot_ctrl #(
  parameter int WIDTH    = 8,
  parameter int RST_HOLD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base_adr,
  input  logic [WIDTH-1:0] load_len,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             cpu_memread,
  input  logic             cpu_memwrite,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_writedata,
  output logic             cpu_reset,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] byte_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

  localparam int              HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_HOLD - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] count_q;
  logic [HW-1:0]    hold_cnt;
  logic             done_q;
  logic             beat;
  logic             last_beat;
  logic             hold_end;

  assign beat      = (state == LOAD) && in_valid;
  assign last_beat = beat && (count_q == len_q - WIDTH'(1));
  assign hold_end  = (state == HOLD) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      count_q  <= '0;
      hold_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      // done marks the first RUN cycle, i.e. the cycle after the hold expires
      done_q <= hold_end;
      case (state)
        IDLE, RUN: begin
          if (start) begin
            base_q   <= base_adr;
            len_q    <= load_len;
            count_q  <= '0;
            hold_cnt <= '0;
            state    <= (load_len != '0) ? LOAD : HOLD;
          end
        end
        LOAD: begin
          if (beat) begin
            count_q <= count_q + WIDTH'(1);
            if (last_beat) begin
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_end) state <= RUN;
          else          hold_cnt <= hold_cnt + HW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port mux: loader owns it in LOAD, core owns it in RUN, idle otherwise
  always_comb begin
    in_ready  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (beat) begin
          mem_write = 1'b1;
          mem_adr   = base_q + count_q;
          mem_wdata = in_data;
        end
      end
      RUN: begin
        mem_read  = cpu_memread;
        mem_write = cpu_memwrite;
        mem_adr   = cpu_adr;
        mem_wdata = cpu_writedata;
      end
      default: ;
    endcase
  end

  assign cpu_reset  = (state != RUN);
  assign busy       = (state == LOAD) || (state == HOLD);
  assign done       = done_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Directed bench for mips_boot_ctrl; memory writes are checked against a queue of expected (adr,data).
module tb_mips_boot_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_adr = '0;
  logic [7:0] load_len = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       cpu_memread = 1'b0;
  logic       cpu_memwrite = 1'b0;
  logic [7:0] cpu_adr = '0;
  logic [7:0] cpu_writedata = '0;
  logic       cpu_reset;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_adr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic [7:0] byte_count;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic [7:0]  exp_adr;

  mips_boot_ctrl #(.WIDTH(8), .RST_HOLD(2)) dut (
    .clk(clk), .reset(reset), .start(start), .base_adr(base_adr), .load_len(load_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr),
    .cpu_writedata(cpu_writedata), .cpu_reset(cpu_reset), .mem_read(mem_read),
    .mem_write(mem_write), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write the memory sees must be the next expected one
  always @(negedge clk) begin
    #2;
    if (mem_write === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write observed=%0h:%0h expected=none", mem_adr, mem_wdata);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("write_adr_data", {mem_adr, mem_wdata}, mon_exp);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back({exp_adr, d});
    #1;
    check("beat_mem_write", mem_write, 1);
    check("beat_mem_adr", mem_adr, exp_adr);
    check("beat_in_ready", in_ready, 1);
    exp_adr = exp_adr + 8'd1;
    cyc();
  endtask

  task automatic begin_load(input logic [7:0] b, input logic [7:0] n);
    start    = 1'b1;
    base_adr = b;
    load_len = n;
    exp_adr  = b;
    cyc();
    start    = 1'b0;
  endtask

  // Two HOLD cycles with the core still in reset, then the first RUN cycle
  task automatic hold_then_run(input string tag, input logic [7:0] cnt);
    in_valid = 1'b0;
    #1;
    check({tag, "_hold1_cpu_reset"}, cpu_reset, 1);
    check({tag, "_hold1_in_ready"}, in_ready, 0);
    check({tag, "_hold1_busy"}, busy, 1);
    check({tag, "_hold1_count"}, byte_count, cnt);
    cyc();
    #1;
    check({tag, "_hold2_cpu_reset"}, cpu_reset, 1);
    check({tag, "_hold2_done"}, done, 0);
    cyc();
    #1;
    check({tag, "_run_cpu_reset"}, cpu_reset, 0);
    check({tag, "_run_done"}, done, 1);
    check({tag, "_run_busy"}, busy, 0);
    cyc();
    #1;
    check({tag, "_run2_done"}, done, 0);
    check({tag, "_run2_count"}, byte_count, cnt);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    // 1: reset
    cyc(); cyc();
    #1;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_byte_count", byte_count, 0);
    reset = 1'b0;
    cyc();

    // 2: three bytes with a gap before the last
    begin_load(8'h10, 8'd3);
    #1;
    check("t2_load_busy", busy, 1);
    check("t2_load_count", byte_count, 0);
    beat(8'hAA);
    beat(8'hBB);
    in_valid = 1'b0;
    #1;
    check("t2_gap_mem_write", mem_write, 0);
    check("t2_gap_in_ready", in_ready, 1);
    check("t2_gap_count", byte_count, 2);
    cyc();
    beat(8'hCC);
    hold_then_run("t2", 8'd3);
    cyc();

    // 3: zero-length load from RUN
    start    = 1'b1;
    base_adr = 8'h40;
    load_len = 8'd0;
    #1;
    check("t3_start_cycle_cpu_reset", cpu_reset, 0);
    cyc();
    start = 1'b0;
    hold_then_run("t3", 8'd0);
    cyc();

    // 4: address wrap
    begin_load(8'hFE, 8'd4);
    beat(8'h01);
    beat(8'h02);
    beat(8'h03);
    beat(8'h04);
    hold_then_run("t4", 8'd4);
    cyc();

    // 5: reset mid-load
    begin_load(8'h80, 8'd5);
    beat(8'h11);
    beat(8'h22);
    in_valid = 1'b0;
    reset    = 1'b1;
    cyc();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h33;
    #1;
    check("t5_in_ready", in_ready, 0);
    check("t5_mem_write", mem_write, 0);
    check("t5_count", byte_count, 0);
    check("t5_cpu_reset", cpu_reset, 1);
    check("t5_busy", busy, 0);
    cyc(); cyc();
    #1;
    check("t5_still_idle_in_ready", in_ready, 0);
    in_valid = 1'b0;
    cyc();

    // 6: pass-through in RUN, then reload from RUN
    begin_load(8'h00, 8'd0);
    hold_then_run("t6a", 8'd0);
    cyc();
    cpu_memwrite  = 1'b1;
    cpu_adr       = 8'h22;
    cpu_writedata = 8'h5A;
    exp_q.push_back({8'h22, 8'h5A});
    #1;
    check("t6_pt_mem_write", mem_write, 1);
    check("t6_pt_mem_adr", mem_adr, 8'h22);
    check("t6_pt_mem_wdata", mem_wdata, 8'h5A);
    check("t6_pt_mem_read", mem_read, 0);
    cyc();
    cpu_memwrite = 1'b0;
    cpu_memread  = 1'b1;
    cpu_adr      = 8'h30;
    #1;
    check("t6_pt_read", mem_read, 1);
    check("t6_pt_read_adr", mem_adr, 8'h30);
    cyc();
    cpu_memread   = 1'b0;
    cpu_memwrite  = 1'b1;
    cpu_adr       = 8'h23;
    cpu_writedata = 8'h77;
    exp_q.push_back({8'h23, 8'h77});
    begin_load(8'h50, 8'd1);
    #1;
    check("t6_reload_cpu_reset", cpu_reset, 1);
    check("t6_reload_in_ready", in_ready, 1);
    check("t6_reload_cpu_ignored", mem_write, 0);
    cyc();
    cpu_memwrite = 1'b0;
    beat(8'h99);
    hold_then_run("t6b", 8'd1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
